uart_boot_loader: RTL and testbench

- Consumes received bytes from the UART RX FIFO and decodes a framed load protocol: sync, address, length, data words, checksum.
- Writes the assembled 32-bit words to the memory bus and returns an ACK/NAK byte through the UART TX FIFO.
- Sits directly downstream of the UART wrapper's RX buffer and upstream of its TX buffer; used to download images at boot.

---
 rtl/uart_boot_loader_pkg.sv | 20 ++
 rtl/uart_byte_shifter.sv | 57 +++++
 rtl/uart_boot_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and protocol constants for the UART boot loader.
package uart_boot_loader_pkg;

    // Frame decoder states; everything except IDLE counts as busy.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        MEMWR,
        CSUM,
        RESP
    } state_e;

    // Default framing bytes (the top module exposes them as parameters).
    localparam logic [7:0] DEF_SYNC     = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_byte_shifter.sv
// Little-endian 4-byte field accumulator with byte index and running
// 8-bit checksum, shared by the address, length and data fields.
module uart_byte_shifter (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        clr_idx,    // restart byte index at lane 0
    input  logic        clr_sum,    // restart checksum
    input  logic        push,       // accept din into current lane and sum
    input  logic [7:0]  din,
    output logic [31:0] word_next,  // word including the byte being pushed
    output logic [1:0]  idx,        // lane the next pushed byte lands in
    output logic [7:0]  csum        // sum of all bytes pushed since clr_sum
);

    logic [31:0] word_q;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;

    // Each byte lane is replaced only when the current index selects it, so
    // the caller can capture the completed word on the same cycle as the
    // final byte without waiting for the register.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (push && idx_q == 2'(gi)) ? din
                                                                    : word_q[gi*8 +: 8];
        end
    endgenerate

    // Next index and checksum; clearing the index wins over advancing it.
    always_comb begin
        idx_d = idx_q;
        sum_d = sum_q;
        if (push) begin
            idx_d = idx_q + 2'd1;
            sum_d = sum_q + din;
        end
        if (clr_idx) idx_d = 2'd0;
        if (clr_sum) sum_d = 8'd0;
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= 32'd0;
            idx_q  <= 2'd0;
            sum_q  <= 8'd0;
        end else begin
            word_q <= word_next;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
        end
    end

    assign idx  = idx_q;
    assign csum = sum_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: decodes SYNC/address/length/data/checksum frames from the
// RX FIFO, writes the words to the memory bus and answers ACK/NAK via TX FIFO.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC     = DEF_SYNC,
    parameter logic [7:0]  ACK_BYTE = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE = DEF_NAK_BYTE,
    parameter logic [23:0] TIMEOUT  = 24'd10000000
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        en,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    output logic        tx_write,
    input  logic        tx_full,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [23:0] timer_q, timer_d;
    logic [31:0] dout_q, dout_d;
    logic        mem_we_q, mem_we_d;
    logic        error_q, error_d;
    logic [7:0]  resp_q, resp_d;
    logic        resp_ack_q, resp_ack_d;

    logic        in_field, want_byte, pop;
    logic        sh_push, sh_clr_idx, sh_clr_sum;
    logic [31:0] word_next;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;

    // Pops are combinational so the head byte is consumed in the same cycle
    // it is seen; gating with rst keeps every output quiet while in reset.
    assign in_field  = (state_q == ADDR) || (state_q == LEN) ||
                       (state_q == DATA) || (state_q == CSUM);
    assign want_byte = in_field || (state_q == IDLE && en);
    assign pop       = rst && want_byte && !rx_empty;

    assign rx_read  = pop;
    assign tx_write = (state_q == RESP) && !tx_full;
    assign done     = tx_write && resp_ack_q;
    assign tx_data  = resp_q;
    assign mem_addr = addr_q;
    assign mem_dout = dout_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q != IDLE);
    assign error    = error_q;

    uart_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr_idx   (sh_clr_idx),
        .clr_sum   (sh_clr_sum),
        .push      (sh_push),
        .din       (rx_data),
        .word_next (word_next),
        .idx       (byte_idx),
        .csum      (csum)
    );

    // Next-state logic: inter-byte timeout first, then per-state decoding.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        timer_d    = timer_q;
        dout_d     = dout_q;
        mem_we_d   = mem_we_q;
        error_d    = error_q;
        resp_d     = resp_q;
        resp_ack_d = resp_ack_q;
        sh_push    = 1'b0;
        sh_clr_idx = 1'b0;
        sh_clr_sum = 1'b0;

        // The timer only advances while waiting for bytes; it freezes in
        // MEMWR and RESP and is restarted by every pop.
        if (in_field) begin
            if (pop) begin
                timer_d = 24'd0;
            end else if (timer_q == TIMEOUT - 24'd1) begin
                timer_d    = 24'd0;
                state_d    = RESP;
                resp_d     = NAK_BYTE;
                resp_ack_d = 1'b0;
                error_d    = 1'b1;
            end else begin
                timer_d = timer_q + 24'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pop && rx_data == SYNC) begin
                    state_d    = ADDR;
                    error_d    = 1'b0;
                    timer_d    = 24'd0;
                    sh_clr_idx = 1'b1;
                    sh_clr_sum = 1'b1;
                end
            end
            ADDR: begin
                if (pop) begin
                    sh_push = 1'b1;
                    if (byte_idx == 2'd3) begin
                        addr_d  = {word_next[31:2], 2'b00};
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (pop) begin
                    sh_push = 1'b1;
                    if (byte_idx == 2'd1) begin
                        sh_clr_idx = 1'b1;
                        len_d      = word_next[15:0];
                        state_d    = (word_next[15:0] == 16'd0) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (pop) begin
                    sh_push = 1'b1;
                    if (byte_idx == 2'd3) begin
                        dout_d   = word_next;
                        mem_we_d = 1'b1;
                        state_d  = MEMWR;
                    end
                end
            end
            MEMWR: begin
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    addr_d   = addr_q + 32'd4;
                    len_d    = len_q - 16'd1;
                    state_d  = (len_q == 16'd1) ? CSUM : DATA;
                end
            end
            CSUM: begin
                if (pop) begin
                    state_d = RESP;
                    if (rx_data == csum) begin
                        resp_d     = ACK_BYTE;
                        resp_ack_d = 1'b1;
                    end else begin
                        resp_d     = NAK_BYTE;
                        resp_ack_d = 1'b0;
                        error_d    = 1'b1;
                    end
                end
            end
            RESP: begin
                if (!tx_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs; reset drops mem_we immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            len_q      <= 16'd0;
            timer_q    <= 24'd0;
            dout_q     <= 32'd0;
            mem_we_q   <= 1'b0;
            error_q    <= 1'b0;
            resp_q     <= 8'd0;
            resp_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            dout_q     <= dout_d;
            mem_we_q   <= mem_we_d;
            error_q    <= error_d;
            resp_q     <= resp_d;
            resp_ack_q <= resp_ack_d;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven frames with a
// scoreboard for memory writes and TX responses, plus hand-written sequences
// for enable gating, timeout, TX back-pressure and asynchronous reset.
module tb_uart_boot_loader;

    localparam logic [23:0] TMO    = 24'd100;
    localparam logic [7:0]  SYNC_B = 8'hA5;
    localparam logic [7:0]  ACK_B  = 8'h06;
    localparam logic [7:0]  NAK_B  = 8'h15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
        int          garbage;
        int          ack_delay;
        bit          force_csum;
        logic [7:0]  csum_val;
        logic [7:0]  exp_resp;
        bit          exp_err;
    } vec_t;

    wr_t        exp_mem[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_fifo[$];
    vec_t       vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop = -100;
    int tx_cycle = 0;
    int pop_cnt = 0;
    int we_run = 0;
    int ack_delay = 0;
    bit do_pop = 1'b0;
    bit full_mode = 1'b0;

    uart_boot_loader #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_read  (rx_read),
        .tx_data  (tx_data),
        .tx_write (tx_write),
        .tx_full  (tx_full),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Environment drivers: RX FIFO head, memory ack and TX back-pressure,
    // updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
            do_pop = 1'b0;
        end
        rx_empty = (rx_fifo.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_fifo[0];
        mem_ack  = mem_we && (we_run == ack_delay);
        tx_full  = full_mode && (cyc - last_pop < 3);
    end

    // Monitor and scoreboard, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rx_read) begin
            chk("rx_read_nonempty", 32'(rx_empty), 32'd0);
            do_pop   = 1'b1;
            last_pop = cyc;
            pop_cnt++;
        end
        if (mem_we) begin
            chk("no_pop_in_memwr", 32'(rx_read), 32'd0);
            chk("write_expected", 32'(exp_mem.size() > 0), 32'd1);
            if (exp_mem.size() > 0) begin
                chk("mem_addr", mem_addr, exp_mem[0].addr);
                chk("mem_dout", mem_dout, exp_mem[0].data);
            end
            if (mem_ack) begin
                $display("write addr=%h data=%h after %0d wait cycles", mem_addr, mem_dout, we_run);
                if (exp_mem.size() > 0) void'(exp_mem.pop_front());
                we_run = 0;
            end else begin
                we_run++;
            end
        end else begin
            if (we_run != 0) chk("mem_we_held_until_ack", 32'(mem_we), 32'd1);
            we_run = 0;
        end
        if (tx_write) begin
            chk("tx_not_full", 32'(tx_full), 32'd0);
            chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) begin
                chk("tx_data", 32'(tx_data), 32'(exp_tx[0]));
                chk("done_on_ack", 32'(done), 32'(exp_tx[0] == ACK_B));
                void'(exp_tx.pop_front());
            end
            tx_cycle = cyc;
            $display("tx byte=%h done=%0b cycle=%0d", tx_data, done, cyc);
        end else if (done) begin
            chk("done_only_with_tx", 32'(tx_write), 32'd1);
        end
    end

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #3;
            if (exp_tx.size() == 0 && !busy && rx_fifo.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_complete"}, 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [7:0] bytes[$];
        logic [7:0] garb[3];
        logic [7:0] sum;
        logic [31:0] w;
        garb[0] = 8'h00;
        garb[1] = 8'hFF;
        garb[2] = 8'h12;
        sum = 8'h00;
        for (int i = 0; i < v.garbage; i++) bytes.push_back(garb[i % 3]);
        bytes.push_back(SYNC_B);
        for (int i = 0; i < 4; i++) begin
            bytes.push_back(v.addr[8*i +: 8]);
            sum += v.addr[8*i +: 8];
        end
        bytes.push_back(v.nwords[7:0]);
        bytes.push_back(v.nwords[15:8]);
        sum += v.nwords[7:0];
        sum += v.nwords[15:8];
        for (int i = 0; i < v.nwords; i++) begin
            w = (i == 0) ? v.w0 : v.w1;
            for (int b = 0; b < 4; b++) begin
                bytes.push_back(w[8*b +: 8]);
                sum += w[8*b +: 8];
            end
            exp_mem.push_back('{addr: {v.addr[31:2], 2'b00} + 32'(4 * i), data: w});
        end
        bytes.push_back(v.force_csum ? v.csum_val : sum);
        exp_tx.push_back(v.exp_resp);
        ack_delay = v.ack_delay;
        foreach (bytes[i]) rx_fifo.push_back(bytes[i]);
        $display("frame %s addr=%h words=%0d csum=%h", name, v.addr, v.nwords,
                 v.force_csum ? v.csum_val : sum);
        wait_idle(2000, name);
        chk({name, "_error"}, 32'(error), 32'(v.exp_err));
        chk({name, "_writes_drained"}, 32'(exp_mem.size()), 32'd0);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int p0;
        int tdiff;
        bit ok;

        //          addr          n  w0            w1            garb dly frc csum   resp   err
        vecs[0] = '{32'h0000_1000, 1, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 8'h00, ACK_B, 1'b0};
        vecs[1] = '{32'h0000_1000, 1, 32'hDEADBEEF, 32'h0,        0, 0, 1'b1, 8'h00, NAK_B, 1'b1};
        vecs[2] = '{32'h0000_1000, 1, 32'hDEADBEEF, 32'h0,        3, 0, 1'b0, 8'h00, ACK_B, 1'b0};
        vecs[3] = '{32'h0000_0003, 0, 32'h0,        32'h0,        0, 0, 1'b0, 8'h00, ACK_B, 1'b0};
        vecs[4] = '{32'h2000_0010, 2, 32'h11223344, 32'h55667788, 0, 5, 1'b0, 8'h00, ACK_B, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 2, 32'hA5A5A5A5, 32'h0BADF00D, 1, 1, 1'b0, 8'h00, ACK_B, 1'b0};
        vecs[6] = '{32'h0000_0107, 1, 32'h12345678, 32'h0,        0, 2, 1'b1, 8'h1C, NAK_B, 1'b1};

        // Reset state, with a byte waiting and enable high.
        rst = 1'b0;
        en  = 1'b1;
        rx_fifo.push_back(8'h00);
        repeat (3) @(posedge clk);
        #3;
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_tx_write", 32'(tx_write), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Enable low blocks pops; SYNC clears the sticky error; stall times out.
        chk("error_sticky", 32'(error), 32'd1);
        en = 1'b0;
        rx_fifo.push_back(SYNC_B);
        rx_fifo.push_back(8'h01);
        rx_fifo.push_back(8'h02);
        rx_fifo.push_back(8'h03);
        rx_fifo.push_back(8'h04);
        exp_tx.push_back(NAK_B);
        p0 = pop_cnt;
        repeat (10) @(posedge clk);
        #3;
        chk("en_low_no_pop", 32'(pop_cnt), 32'(p0));
        chk("en_low_idle", 32'(busy), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 50 && rx_fifo.size() != 0; i++) begin
            @(posedge clk);
            #3;
        end
        chk("sync_clears_error", 32'(error), 32'd0);
        chk("busy_in_frame", 32'(busy), 32'd1);
        en = 1'b0;
        wait_idle(500, "timeout");
        tdiff = tx_cycle - last_pop;
        $display("timeout nak %0d cycles after last pop", tdiff);
        chk("timeout_window", 32'(tdiff >= int'(TMO) && tdiff <= int'(TMO) + 1), 32'd1);
        chk("timeout_error", 32'(error), 32'd1);
        en = 1'b1;

        // TX FIFO full for 3 cycles after the checksum byte.
        full_mode = 1'b1;
        run_vec(vecs[3], "txfull");
        chk("tx_full_delay", 32'(tx_cycle - last_pop), 32'd4);
        full_mode = 1'b0;

        // Reset while a write is pending.
        ack_delay = 1000;
        rx_fifo.push_back(SYNC_B);
        rx_fifo.push_back(8'h80);
        rx_fifo.push_back(8'h00);
        rx_fifo.push_back(8'h00);
        rx_fifo.push_back(8'h00);
        rx_fifo.push_back(8'h01);
        rx_fifo.push_back(8'h00);
        rx_fifo.push_back(8'h0D);
        rx_fifo.push_back(8'hF0);
        rx_fifo.push_back(8'hFE);
        rx_fifo.push_back(8'hCA);
        exp_mem.push_back('{addr: 32'h0000_0080, data: 32'hCAFEF00D});
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #3;
            if (mem_we) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_memwr", 32'(ok), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        we_run = 0;
        chk("async_rst_mem_we", 32'(mem_we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_error", 32'(error), 32'd0);
        chk("async_rst_mem_addr", mem_addr, 32'd0);
        chk("async_rst_mem_dout", mem_dout, 32'd0);
        chk("async_rst_tx_write", 32'(tx_write), 32'd0);
        chk("async_rst_rx_read", 32'(rx_read), 32'd0);
        exp_mem.delete();
        exp_tx.delete();
        rx_fifo.delete();
        do_pop = 1'b0;
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_vec(vecs[0], "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
